// File: rtl/fr_adder_sched_pkg.sv
// Shared constants and types for the fraction-adder scheduler.
package fr_adder_sched_pkg;

  localparam int unsigned FR_W        = 24;
  localparam int unsigned DEF_LATENCY = 8;
  localparam int unsigned DEF_MAX_OUT = 4;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  // One in-flight operation: occupied flag plus the lane that owns it.
  typedef struct packed {
    logic valid;
    logic lane;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, lane: 1'b0};

endpackage

// File: rtl/fr_rr_arb2.sv
// Two-way round-robin arbiter: grants the pointed-to lane when eligible,
// otherwise the other lane; pointer moves to the lane not granted.
module fr_rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] elig,
  output logic [1:0] grant,
  output logic       ptr
);

  // Priority to the pointer lane, fall back to the other one.
  always_comb begin
    grant = '0;
    if (elig[ptr]) begin
      grant[ptr] = 1'b1;
    end else if (elig[~ptr]) begin
      grant[~ptr] = 1'b1;
    end
  end

  // Pointer becomes the non-granted lane; holds when nothing is granted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (grant[0]) begin
      ptr <= 1'b1;
    end else if (grant[1]) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/fr_adder_sched.sv
// Two-lane scheduler for a shared pipelined fraction adder: round-robin
// issue, tag pipe matching the adder depth, per-lane credit limiting.
module fr_adder_sched
  import fr_adder_sched_pkg::*;
#(
  parameter int unsigned LATENCY = DEF_LATENCY,
  parameter int unsigned MAX_OUT = DEF_MAX_OUT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            issue_en,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [FR_W-1:0] req0_in1,
  input  logic [FR_W-1:0] req0_in2,
  input  logic            req0_sign_in1,
  input  logic            req0_sign_in2,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [FR_W-1:0] req1_in1,
  input  logic [FR_W-1:0] req1_in2,
  input  logic            req1_sign_in1,
  input  logic            req1_sign_in2,
  output logic [FR_W-1:0] add_in1,
  output logic [FR_W-1:0] add_in2,
  output logic            add_sign_in1,
  output logic            add_sign_in2,
  input  logic [FR_W-1:0] add_out,
  input  logic            add_out_sign,
  input  logic            add_overflow,
  output logic            res0_valid,
  output logic [FR_W-1:0] res0_out,
  output logic            res0_sign,
  output logic            res0_overflow,
  output logic            res1_valid,
  output logic [FR_W-1:0] res1_out,
  output logic            res1_sign,
  output logic            res1_overflow,
  output logic            busy
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;
  logic [1:0]    elig;
  logic [1:0]    grant;
  logic          ptr;
  tag_t          issue_tag;
  tag_t          tpipe [LATENCY];
  tag_t          tail;
  logic          pipe_any;

  // A lane competes only while issuing is enabled and it holds a credit.
  always_comb begin
    elig[0] = issue_en & req0_valid & (cnt0 < CW'(MAX_OUT));
    elig[1] = issue_en & req1_valid & (cnt1 < CW'(MAX_OUT));
  end

  fr_rr_arb2 u_arb (
    .clock (clock),
    .reset (reset),
    .elig  (elig),
    .grant (grant),
    .ptr   (ptr)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign tail       = tpipe[LATENCY-1];

  // Issue register: load granted operands, otherwise feed zeros and an idle tag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      add_in1      <= '0;
      add_in2      <= '0;
      add_sign_in1 <= 1'b0;
      add_sign_in2 <= 1'b0;
      issue_tag    <= TAG_IDLE;
    end else if (grant[LANE0]) begin
      add_in1      <= req0_in1;
      add_in2      <= req0_in2;
      add_sign_in1 <= req0_sign_in1;
      add_sign_in2 <= req0_sign_in2;
      issue_tag    <= '{valid: 1'b1, lane: LANE0};
    end else if (grant[LANE1]) begin
      add_in1      <= req1_in1;
      add_in2      <= req1_in2;
      add_sign_in1 <= req1_sign_in1;
      add_sign_in2 <= req1_sign_in2;
      issue_tag    <= '{valid: 1'b1, lane: LANE1};
    end else begin
      add_in1      <= '0;
      add_in2      <= '0;
      add_sign_in1 <= 1'b0;
      add_sign_in2 <= 1'b0;
      issue_tag    <= TAG_IDLE;
    end
  end

  // Tag pipe shadows the adder so its tail lines up with add_out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        tpipe[i] <= TAG_IDLE;
      end
    end else begin
      tpipe[0] <= issue_tag;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tpipe[i] <= tpipe[i-1];
      end
    end
  end

  // Result registers: route the adder output to the owning lane, hold between strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res0_valid    <= 1'b0;
      res0_out      <= '0;
      res0_sign     <= 1'b0;
      res0_overflow <= 1'b0;
      res1_valid    <= 1'b0;
      res1_out      <= '0;
      res1_sign     <= 1'b0;
      res1_overflow <= 1'b0;
    end else begin
      res0_valid <= tail.valid && (tail.lane == LANE0);
      res1_valid <= tail.valid && (tail.lane == LANE1);
      if (tail.valid && (tail.lane == LANE0)) begin
        res0_out      <= add_out;
        res0_sign     <= add_out_sign;
        res0_overflow <= add_overflow;
      end
      if (tail.valid && (tail.lane == LANE1)) begin
        res1_out      <= add_out;
        res1_sign     <= add_out_sign;
        res1_overflow <= add_overflow;
      end
    end
  end

  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c,
                                             input logic inc, input logic dec);
    if (inc && !dec) return c + CW'(1);
    if (dec && !inc) return c - CW'(1);
    return c;
  endfunction

  // Credits: taken on grant, returned on the lane's result strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      cnt0 <= cnt_next(cnt0, grant[0], res0_valid);
      cnt1 <= cnt_next(cnt1, grant[1], res1_valid);
    end
  end

  // Busy while anything sits in the issue stage, the pipe, or holds a credit.
  always_comb begin
    pipe_any = 1'b0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      pipe_any = pipe_any | tpipe[i].valid;
    end
    busy = issue_tag.valid | pipe_any | (cnt0 != '0) | (cnt1 != '0);
  end

endmodule

// File: tb/tb_fr_adder_sched.sv
// Scoreboard bench for fr_adder_sched with a behavioural pipelined adder.
module tb_fr_adder_sched;

  localparam int unsigned LAT  = 8;
  localparam int unsigned MAXO = 4;
  localparam int          RTT  = LAT + 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        issue_en = 1'b0;
  logic        req0_valid, req0_ready, req0_sign_in1, req0_sign_in2;
  logic [23:0] req0_in1, req0_in2;
  logic        req1_valid, req1_ready, req1_sign_in1, req1_sign_in2;
  logic [23:0] req1_in1, req1_in2;
  logic [23:0] add_in1, add_in2, add_out;
  logic        add_sign_in1, add_sign_in2, add_out_sign, add_overflow;
  logic        res0_valid, res0_sign, res0_overflow;
  logic [23:0] res0_out;
  logic        res1_valid, res1_sign, res1_overflow;
  logic [23:0] res1_out;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_xfer = 0;

  typedef struct {
    logic        lane;
    logic [23:0] out;
    logic        sign;
    logic        ovf;
    int          cyc;
  } exp_t;

  typedef struct {
    int cyc;
    int lane;
  } ret_t;

  exp_t sb[$];
  ret_t ret_q[$];
  int   outs[2];
  int   mptr;
  logic [1:0] elig, eg, act;
  logic [25:0] r;
  exp_t e;
  ret_t rt;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  fr_adder_sched #(.LATENCY(LAT), .MAX_OUT(MAXO)) dut (
    .clock(clock), .reset(reset), .issue_en(issue_en),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1), .req0_in2(req0_in2),
    .req0_sign_in1(req0_sign_in1), .req0_sign_in2(req0_sign_in2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1), .req1_in2(req1_in2),
    .req1_sign_in1(req1_sign_in1), .req1_sign_in2(req1_sign_in2),
    .add_in1(add_in1), .add_in2(add_in2), .add_sign_in1(add_sign_in1), .add_sign_in2(add_sign_in2),
    .add_out(add_out), .add_out_sign(add_out_sign), .add_overflow(add_overflow),
    .res0_valid(res0_valid), .res0_out(res0_out), .res0_sign(res0_sign), .res0_overflow(res0_overflow),
    .res1_valid(res1_valid), .res1_out(res1_out), .res1_sign(res1_sign), .res1_overflow(res1_overflow),
    .busy(busy)
  );

  // Signed-magnitude fraction add: {carry, sign, sum}.
  function automatic logic [25:0] add_ref(input logic [23:0] a, input logic [23:0] b,
                                          input logic sa, input logic sb_);
    logic [24:0] s;
    if (sa == sb_) begin
      s = {1'b0, a} + {1'b0, b};
      return {s[24], sa, s[23:0]};
    end else if (a >= b) begin
      return {1'b0, sa, a - b};
    end else begin
      return {1'b0, sb_, b - a};
    end
  endfunction

  // Behavioural adder: LAT stages after the capture edge.
  logic [25:0] apipe [LAT];
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) apipe[i] <= '0;
    end else begin
      apipe[0] <= add_ref(add_in1, add_in2, add_sign_in1, add_sign_in2);
      for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
  end
  assign {add_overflow, add_out_sign, add_out} = apipe[LAT-1];

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act_v, exp_v);
    end
  endtask

  // Issue observer: reference arbitration/credit model, pushes expected results.
  always @(negedge clock) begin
    if (reset) begin
      mptr = 0;
      outs[0] = 0;
      outs[1] = 0;
      ret_q.delete();
    end else begin
      check("busy", 32'(busy), 32'((outs[0] + outs[1]) != 0));
      elig[0] = issue_en && req0_valid && (outs[0] < int'(MAXO));
      elig[1] = issue_en && req1_valid && (outs[1] < int'(MAXO));
      eg = 2'b00;
      if (elig[mptr]) eg[mptr] = 1'b1;
      else if (elig[1-mptr]) eg[1-mptr] = 1'b1;
      check("ready_pair", 32'({req1_ready, req0_ready}), 32'(eg));
      act = {req1_valid & req1_ready, req0_valid & req0_ready};
      if (act[0]) begin
        r = add_ref(req0_in1, req0_in2, req0_sign_in1, req0_sign_in2);
        e.lane = 1'b0; e.out = r[23:0]; e.sign = r[24]; e.ovf = r[25]; e.cyc = cyc;
        sb.push_back(e);
        n_xfer++;
      end
      if (act[1]) begin
        r = add_ref(req1_in1, req1_in2, req1_sign_in1, req1_sign_in2);
        e.lane = 1'b1; e.out = r[23:0]; e.sign = r[24]; e.ovf = r[25]; e.cyc = cyc;
        sb.push_back(e);
        n_xfer++;
      end
      while (ret_q.size() > 0 && ret_q[0].cyc == cyc) begin
        rt = ret_q.pop_front();
        outs[rt.lane]--;
      end
      for (int l = 0; l < 2; l++) begin
        if (eg[l]) begin
          outs[l]++;
          rt.cyc = cyc + RTT;
          rt.lane = l;
          ret_q.push_back(rt);
          mptr = 1 - l;
        end
      end
    end
  end

  // Result monitor: pops the scoreboard on every result strobe.
  exp_t m;
  logic mlane;
  always @(negedge clock) begin
    if (reset) begin
      sb.delete();
    end else if (res0_valid || res1_valid) begin
      check("single_strobe", 32'(res0_valid & res1_valid), 32'(0));
      mlane = res1_valid;
      check("strobe_expected", 32'(sb.size() > 0), 32'(1));
      if (sb.size() > 0) begin
        m = sb.pop_front();
        check("res_lane", 32'(mlane), 32'(m.lane));
        check("res_latency", 32'(cyc - m.cyc), 32'(RTT));
        check("res_out", 32'(mlane ? res1_out : res0_out), 32'(m.out));
        check("res_sign", 32'(mlane ? res1_sign : res0_sign), 32'(m.sign));
        check("res_ovf", 32'(mlane ? res1_overflow : res0_overflow), 32'(m.ovf));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ops(input int lane, input logic v, input logic [23:0] a, input logic [23:0] b,
                         input logic sa, input logic sb_);
    if (lane == 0) begin
      req0_valid = v; req0_in1 = a; req0_in2 = b; req0_sign_in1 = sa; req0_sign_in2 = sb_;
    end else begin
      req1_valid = v; req1_in1 = a; req1_in2 = b; req1_sign_in1 = sa; req1_sign_in2 = sb_;
    end
  endtask

  task automatic rand_ops(input int lane, input logic v);
    set_ops(lane, v, 24'($urandom), 24'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic drive_one(input int lane, input logic [23:0] a, input logic [23:0] b,
                           input logic sa, input logic sb_);
    int start;
    start = n_xfer;
    set_ops(lane, 1'b1, a, b, sa, sb_);
    for (int k = 0; k < 50 && n_xfer == start; k++) step();
    check("xfer_timeout", 32'(n_xfer == start), 32'(0));
    set_ops(lane, 1'b0, a, b, sa, sb_);
  endtask

  initial begin
    int start;
    set_ops(0, 1'b0, '0, '0, 1'b0, 1'b0);
    set_ops(1, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    // Reset state
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_add_in1", 32'(add_in1), 32'(0));
    check("rst_res0_out", 32'(res0_out), 32'(0));
    check("rst_res1_valid", 32'(res1_valid), 32'(0));
    check("rst_ready_idle", 32'(req0_ready), 32'(0));
    issue_en = 1'b1;
    req0_valid = 1'b1;
    #1;
    check("rst_ready_rule", 32'(req0_ready), 32'(1));
    req0_valid = 1'b0;
    step();
    reset = 1'b0;
    step();

    // Single lane-0 op: explicit latency and value
    drive_one(0, 24'h400000, 24'h400000, 1'b0, 1'b0);
    repeat (RTT - 1) step();
    check("single_res0_valid", 32'(res0_valid), 32'(1));
    check("single_res0_out", 32'(res0_out), 32'h800000);
    check("single_res0_ovf", 32'(res0_overflow), 32'(0));
    step();
    check("single_pulse_end", 32'(res0_valid), 32'(0));
    check("single_hold", 32'(res0_out), 32'h800000);
    repeat (3) step();

    // Carry-out on lane 1
    drive_one(1, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0);
    repeat (RTT - 1) step();
    check("carry_res1_valid", 32'(res1_valid), 32'(1));
    check("carry_res1_out", 32'(res1_out), 32'hFFFFFE);
    check("carry_res1_ovf", 32'(res1_overflow), 32'(1));
    repeat (5) step();

    // Both lanes continuously valid: alternation and credit stalls
    for (int i = 0; i < 60; i++) begin
      rand_ops(0, 1'b1);
      rand_ops(1, 1'b1);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (15) step();

    // issue_en dropped mid-stream, then resumed
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (5) step();
    issue_en = 1'b0;
    repeat (20) step();
    issue_en = 1'b1;
    repeat (10) step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (15) step();

    // Reset with six operations in flight
    start = n_xfer;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 30 && n_xfer < start + 6; k++) step();
    check("inflight_reached", 32'(n_xfer >= start + 6), 32'(1));
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_res0_valid", 32'(res0_valid), 32'(0));
    check("midrst_res1_valid", 32'(res1_valid), 32'(0));
    step();
    step();
    reset = 1'b0;
    repeat (15) step();
    drive_one(0, 24'h123456, 24'h011111, 1'b1, 1'b1);
    repeat (RTT - 1) step();
    check("postrst_res0_valid", 32'(res0_valid), 32'(1));
    check("postrst_res0_out", 32'(res0_out), 32'h134567);
    repeat (10) step();

    // Same-cycle grant and return on lane 1 at MAX_OUT-1 credits used
    rand_ops(1, 1'b1);
    step(); rand_ops(1, 1'b1);
    step(); rand_ops(1, 1'b1);
    step(); req1_valid = 1'b0;
    repeat (RTT - 3) step();
    rand_ops(1, 1'b1);
    #1;
    check("same_cycle_ready", 32'(req1_ready), 32'(1));
    check("same_cycle_strobe", 32'(res1_valid), 32'(1));
    step();
    rand_ops(1, 1'b1);
    #1;
    check("same_cycle_ready_after", 32'(req1_ready), 32'(1));
    step();
    req1_valid = 1'b0;
    repeat (15) step();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      rand_ops(0, 1'($urandom_range(0, 9) < 7));
      rand_ops(1, 1'($urandom_range(0, 9) < 7));
      issue_en = 1'($urandom_range(0, 9) != 0);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; issue_en = 1'b1;

    for (int k = 0; k < 40 && sb.size() > 0; k++) step();
    check("drain_empty", 32'(sb.size()), 32'(0));
    repeat (2) step();
    check("final_busy", 32'(busy), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fr_adder_sched.md
# fr_adder_sched

Two-requester scheduler for the pipelined 24-bit Kogge-Stone fraction adder `fr_adder`.
- Arbitrates round-robin between two MAC lanes and issues at most one operation per cycle into the shared adder.
- Tracks each in-flight operation with a tag pipeline that matches the adder depth, and returns each result to the lane that issued it.
- Limits outstanding operations per lane with credit counters.
- Sits between the MAC lane front-ends and one `fr_adder` instance. The top level ties adder `resetn = ~reset`.

## Interface
Parameters:
- LATENCY, 8, adder pipeline depth: cycles from the adder input capture edge to a valid `out`.
- MAX_OUT, 4, maximum in-flight operations per lane (credit limit), range 1..LATENCY+2.

Ports (`x` = 0 or 1):
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_en  in  1  when low, no new grants are made; in-flight operations still complete.
- reqx_valid  in  1  lane x has an operation pending.
- reqx_ready  out  1  lane x may issue this cycle.
- reqx_in1, reqx_in2  in  24  fraction operands.
- reqx_sign_in1, reqx_sign_in2  in  1  operand signs.
- add_in1, add_in2  out  24  registered operands to the adder.
- add_sign_in1, add_sign_in2  out  1  registered operand signs to the adder.
- add_out  in  24  adder sum.
- add_out_sign  in  1  adder result sign.
- add_overflow  in  1  adder carry-out.
- resx_valid  out  1  one-cycle result strobe for lane x; no backpressure.
- resx_out  out  24  registered result.
- resx_sign  out  1  registered result sign.
- resx_overflow  out  1  registered carry-out.
- busy  out  1  any operation issued and not yet returned.

## Operation
- **Ready rule:** reqx_ready = issue_en & (cnt_x < MAX_OUT) & (grant selects x). It is computed combinationally from reqx_valid, the round-robin pointer and the credit counters. A transfer occurs when valid & ready.
- **Arbitration:**
  - 1-bit pointer `ptr`.
  - If req[ptr] is eligible (valid and has credit), grant ptr. Otherwise grant the other lane if it is eligible.
  - After any grant, ptr becomes the non-granted lane.
  - With no grant, ptr holds.
  - At most one grant per cycle.
- **Issue register:**
  - On a grant, the operands and signs load into the add_* registers and issue tag {valid=1, lane} is set.
  - With no grant, the add_* registers load zero and the tag valid is 0. Garbage in the adder pipe is never forwarded.
- **Tag pipe:** LATENCY-deep shift register of {valid, lane}, advanced every cycle. Its tail aligns with add_out.
- **Result register:**
  - When the tail is valid, add_out, add_out_sign and add_overflow load into resL_*, and resL_valid pulses for one cycle (L = tail lane).
  - res*_valid for the other lane is 0.
  - res data fields hold their value between strobes.
- **Credits:** cnt_x is 0..MAX_OUT, width clog2(MAX_OUT+1).
  - +1 on a grant to x.
  - −1 when resx_valid is asserted.
  - Unchanged when both happen in the same cycle.
  - Overflow and underflow cannot occur; the bench asserts this.
- **busy** = issue tag valid | any tag pipe valid | any cnt_x ≠ 0.
- **issue_en:** deassertion stops new grants from the same cycle. Reassertion resumes with the pointer unchanged.

## Timing
- **Latency:** a transfer in cycle 0 gives add_* valid in cycle 1, add_out valid in cycle 1+LATENCY, and resx_valid in cycle 2+LATENCY (10 with the defaults).
- **Throughput:** one operation per cycle total. Results return in issue order.
- **Reset values:** ptr=0, all counters 0, all tag valids 0, add_* = 0, res*_* = 0, reqx_ready follows its rule (high once issue_en=1 and valid), busy=0.
- **Reset mid-operation:** all tags and counters clear immediately. No result strobes are generated for the discarded operations. The adder is reset by the same signal.
- **Simultaneous valids, full credit:** grants alternate 0,1,0,1… starting with lane 0 after reset.
- **Credit full on one lane:** the other lane is granted every cycle it is valid.

## Structure
- **Package `fr_adder_sched_pkg`:**
  - FR_W = 24.
  - LATENCY default.
  - Tag struct {logic valid; logic lane}.
  - Lane index constants LANE0=0 and LANE1=1.
- **Sub-module `fr_rr_arb2`:** 2-way round-robin arbiter with an eligibility input, grant one-hot and pointer update.
- **Kept in the top:** tag pipe, credits and registers.

## Test plan
- **Single lane 0 operation:** in1=0x400000, in2=0x400000, same signs → res0_valid exactly 10 cycles after the transfer, res0_out=0x800000, overflow=0, res1_valid never set.
- **Both lanes valid continuously with MAX_OUT=4:**
  - Grants alternate 0,1,0,1.
  - Each lane stalls after 4 outstanding until its first result returns.
  - Steady state shows credits re-granted in the cycle after resx_valid.
  - Results are in issue order with correct lane routing.
- **Carry-out:** in1=in2=0xFFFFFF, same sign → res_out=0xFFFFFE, res_overflow=1.
- **issue_en dropped mid-stream:**
  - No grants while it is low.
  - The in-flight results all return.
  - busy falls 1 cycle after the last res strobe.
  - Resume starts at the preserved pointer.
- **Reset asserted with 6 operations in flight:** zero result strobes afterward, counters=0, busy=0 in the same cycle. A new operation issued after release returns correctly at +10.
- **Same-cycle grant and return on lane 1 with cnt1=MAX_OUT−1:** cnt1 stays unchanged and req1_ready remains 1.
